layer2_pool_ctrl: RTL and testbench

Sequencer for the layer-2 2x2 max-pool datapath. It walks a conv feature map held in a 1-cycle-latency RAM in 2x2 windows, reads the four pixel words of each window, packs them into the per-channel window bus the pool array expects, and pulses the pool start. It then waits for the pool ready and writes the pooled word to the output RAM. It sits between the layer-2 conv output buffer and the layer-3 input buffer.

---
 rtl/layer2_pool_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_layer2_pool_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer2_pool_ctrl.sv
// layer2_pool_ctrl: walks a feature map in 2x2 windows and drives the pool array.
// Optional pool watchdog with sticky err: define POOL_CTRL_TIMEOUT_EN.
module layer2_pool_ctrl #(
    parameter int bits        = 16,
    parameter int channel_num = 8,
    parameter int img_w       = 8,
    parameter int img_h       = 8,
    parameter int addr_bits   = 10
) (
    input  logic                             clk_in,
    input  logic                             rst_n,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic                             fm_rd_en,
    output logic [addr_bits-1:0]             fm_rd_addr,
    input  logic [channel_num*bits-1:0]      fm_rd_data,
    output logic [4*channel_num*bits-1:0]    pool_data_in,
    output logic                             pool_start,
    input  logic [channel_num*bits-1:0]      pool_data_out,
    input  logic                             pool_ready,
    output logic                             out_wr_en,
    output logic [addr_bits-1:0]             out_wr_addr,
    output logic [channel_num*bits-1:0]      out_wr_data
);

    localparam logic [addr_bits-1:0] ONE      = addr_bits'(1);
    localparam logic [addr_bits-1:0] TWO      = addr_bits'(2);
    localparam logic [addr_bits-1:0] W_A      = addr_bits'(img_w);
    localparam logic [addr_bits-1:0] COL_LAST = addr_bits'(img_w - 2);
    localparam logic [addr_bits-1:0] ROW_LAST = addr_bits'(img_h - 2);

    typedef enum logic [2:0] {
        IDLE, RD, CAP, FIRE, WAIT, WR, DONE
    } state_t;

    state_t               state, state_nx;
    logic [1:0]           slot, cap_k;
    logic [addr_bits-1:0] base, base_nx, col, row, out_addr;
    logic                 row_end, last_win, take, tmo, cap_en;

    assign row_end  = (col == COL_LAST);
    assign last_win = row_end && (row == ROW_LAST);
    assign take     = ((state == FIRE) || (state == WAIT)) && pool_ready;
    assign base_nx  = row_end ? base + W_A + TWO : base + TWO;

    // Read data lags the strobe by one cycle, so slot k lands one state later.
    assign cap_en = ((state == RD) && (slot != 2'd0)) || (state == CAP);
    assign cap_k  = (state == CAP) ? 2'd3 : slot - 2'd1;

`ifdef POOL_CTRL_TIMEOUT_EN
    logic [3:0] wdog;

    assign tmo = (state == WAIT) && !pool_ready && (wdog == 4'd14);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= 4'd0;
            err  <= 1'b0;
        end else begin
            wdog <= (state == WAIT) ? wdog + 4'd1 : 4'd0;
            if ((state == IDLE) && start)
                err <= 1'b0;
            else if (tmo)
                err <= 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = RD;
            RD:   if (slot == 2'd3) state_nx = CAP;
            CAP:  state_nx = FIRE;
            FIRE: state_nx = pool_ready ? WR : WAIT;
            WAIT: begin
                if (pool_ready)
                    state_nx = WR;
                else if (tmo)
                    state_nx = DONE;
            end
            WR:   state_nx = last_win ? DONE : RD;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            fm_rd_en    <= 1'b0;
            fm_rd_addr  <= '0;
            pool_start  <= 1'b0;
            out_wr_en   <= 1'b0;
            out_wr_addr <= '0;
            out_wr_data <= '0;
            slot        <= 2'd0;
            base        <= '0;
            col         <= '0;
            row         <= '0;
            out_addr    <= '0;
        end else begin
            fm_rd_en   <= 1'b0;
            pool_start <= 1'b0;
            out_wr_en  <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        row        <= '0;
                        col        <= '0;
                        base       <= '0;
                        out_addr   <= '0;
                        slot       <= 2'd0;
                        fm_rd_en   <= 1'b1;
                        fm_rd_addr <= '0;
                    end
                end
                RD: begin
                    slot <= slot + 2'd1;
                    if (slot != 2'd3)
                        fm_rd_en <= 1'b1;
                    unique case (slot)
                        2'd0: fm_rd_addr <= base + ONE;
                        2'd1: fm_rd_addr <= base + W_A;
                        2'd2: fm_rd_addr <= base + W_A + ONE;
                        default: fm_rd_addr <= fm_rd_addr;
                    endcase
                end
                CAP: pool_start <= 1'b1;
                FIRE, WAIT: begin
                    if (take) begin
                        out_wr_en   <= 1'b1;
                        out_wr_addr <= out_addr;
                        out_wr_data <= pool_data_out;
                    end else if (tmo) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                WR: begin
                    out_addr <= out_addr + ONE;
                    if (last_win) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        col        <= row_end ? '0 : col + TWO;
                        row        <= row_end ? row + TWO : row;
                        base       <= base_nx;
                        slot       <= 2'd0;
                        fm_rd_en   <= 1'b1;
                        fm_rd_addr <= base_nx;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pool_data_in <= '0;
        end else if (cap_en) begin
            for (int c = 0; c < channel_num; c++)
                pool_data_in[(4*c + int'(cap_k))*bits +: bits]
                    <= fm_rd_data[c*bits +: bits];
        end
    end

endmodule

// File: tb/tb_layer2_pool_ctrl.sv
// tb_layer2_pool_ctrl: table-driven and randomized checks of the pool sequencer.
// Reference model works on window coordinates and plain max arithmetic.
module tb_layer2_pool_ctrl;

    localparam int BITS = 16;
    localparam int CH   = 2;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int AB   = 6;
    localparam int WORD = CH*BITS;
    localparam int NWIN = (W/2)*(H/2);

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, err, fm_rd_en, pool_start, out_wr_en;
    logic              pool_ready = 1'b0;
    logic [AB-1:0]     fm_rd_addr, out_wr_addr;
    logic [WORD-1:0]   fm_rd_data = '0;
    logic [WORD-1:0]   pool_data_out = '0;
    logic [WORD-1:0]   out_wr_data;
    logic [4*WORD-1:0] pool_data_in;

    layer2_pool_ctrl #(
        .bits(BITS), .channel_num(CH), .img_w(W), .img_h(H), .addr_bits(AB)
    ) dut (
        .clk_in(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .err(err),
        .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr),
        .fm_rd_data(fm_rd_data), .pool_data_in(pool_data_in),
        .pool_start(pool_start), .pool_data_out(pool_data_out),
        .pool_ready(pool_ready), .out_wr_en(out_wr_en),
        .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
    );

    always #5 clk = ~clk;

    logic [WORD-1:0] mem [W*H];

    always @(posedge clk)
        if (fm_rd_en) fm_rd_data <= mem[fm_rd_addr];

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pool array stand-in: -1 never ready, -2 random delay per window.
    int rdy_dly = 1;
    int pend = 0;
    int cnt = 0;
    int cur = 0;
    int dly_q[$];

    function automatic logic [WORD-1:0] pool_max(input logic [4*WORD-1:0] win);
        logic [WORD-1:0] r;
        logic [BITS-1:0] m, v;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            m = '0;
            for (int k = 0; k < 4; k++) begin
                v = win[(4*c+k)*BITS +: BITS];
                if (v > m) m = v;
            end
            r[c*BITS +: BITS] = m;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
            pool_ready = 1'b0;
        end else begin
            if (pool_start) begin
                pend = 1;
                cnt = 0;
                pool_data_out = pool_max(pool_data_in);
                cur = (rdy_dly == -2) ? int'($urandom_range(0, 6)) : rdy_dly;
                if (rdy_dly == -2) dly_q.push_back(cur);
            end else if (pend != 0) begin
                cnt++;
            end
            if (pend != 0 && cur >= 0 && cnt == cur) begin
                pool_ready = 1'b1;
                pend = 0;
            end else begin
                pool_ready = 1'b0;
            end
        end
    end

    function automatic int px_addr(input int w, input int k);
        int r, c;
        r = 2*(w/(W/2));
        c = 2*(w%(W/2));
        return (r + k/2)*W + c + k%2;
    endfunction

    function automatic logic [4*WORD-1:0] win_exp(input int w);
        logic [4*WORD-1:0] r;
        logic [WORD-1:0] px;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            px = mem[px_addr(w, k)];
            for (int c = 0; c < CH; c++)
                r[(4*c+k)*BITS +: BITS] = px[c*BITS +: BITS];
        end
        return r;
    endfunction

    function automatic logic [WORD-1:0] max_exp(input int w);
        logic [WORD-1:0] r, px;
        int m, v;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            m = 0;
            for (int k = 0; k < 4; k++) begin
                px = mem[px_addr(w, k)];
                v = int'(px[c*BITS +: BITS]);
                m = (v > m) ? v : m;
            end
            r[c*BITS +: BITS] = BITS'(m);
        end
        return r;
    endfunction

    function automatic logic [63:0] outs();
        return {busy, done, err, fm_rd_en, fm_rd_addr, pool_start,
                out_wr_en, out_wr_addr, out_wr_data};
    endfunction

    logic [AB-1:0]     rd_q[$];
    logic [AB-1:0]     wa_q[$];
    logic [WORD-1:0]   wd_q[$];
    logic [4*WORD-1:0] win_q[$];
    int busy_bad, hold_bad;

    task automatic run_pass(input int dly, input bit inject,
                            output int dcyc, output logic err1);
        logic [4*WORD-1:0] snap;
        bit held;
        rdy_dly = dly;
        rd_q.delete(); wa_q.delete(); wd_q.delete(); win_q.delete();
        dly_q.delete();
        busy_bad = 0; hold_bad = 0; dcyc = -1; err1 = 1'bx;
        held = 0; snap = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 1; n <= 600; n++) begin
            if (n == 1) err1 = err;
            if (fm_rd_en) rd_q.push_back(fm_rd_addr);
            if (held && !pool_start && pool_data_in !== snap) hold_bad++;
            if (pool_start) begin
                win_q.push_back(pool_data_in);
                snap = pool_data_in;
                held = 1;
            end
            if (out_wr_en) begin
                wa_q.push_back(out_wr_addr);
                wd_q.push_back(out_wr_data);
                held = 0;
            end
            if (done) begin
                dcyc = n;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
            if (inject) start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", dcyc >= 0, 1);
    endtask

    task automatic check_pass(input string nm, input int dc, input int exp_done);
        check({nm, "_done_cyc"}, dc, exp_done);
        check({nm, "_busy"}, busy_bad, 0);
        check({nm, "_hold"}, hold_bad, 0);
        check({nm, "_n_rd"}, rd_q.size(), 4*NWIN);
        check({nm, "_n_wr"}, wa_q.size(), NWIN);
        check({nm, "_n_win"}, win_q.size(), NWIN);
        for (int i = 0; i < rd_q.size() && i < 4*NWIN; i++)
            check({nm, "_rd_addr"}, rd_q[i], px_addr(i/4, i%4));
        for (int i = 0; i < wa_q.size() && i < NWIN; i++) begin
            check({nm, "_wr_addr"}, wa_q[i], i);
            check({nm, "_wr_data"}, wd_q[i], max_exp(i));
        end
        for (int i = 0; i < win_q.size() && i < NWIN; i++)
            check({nm, "_window"}, win_q[i], win_exp(i));
    endtask

    typedef struct {
        int dly;
        bit inject;
        int exp_done;
    } vec_t;

    vec_t vecs[5];
    logic [WORD-1:0] basic_wr[4];
    logic [4*WORD-1:0] basic_win0;
    logic [AB-1:0] basic_rd[8];

    initial begin
        int dc, ps, e;
        logic e1;
        vecs[0] = '{0, 1'b0, 29};
        vecs[1] = '{5, 1'b0, 49};
        vecs[2] = '{1, 1'b1, 33};
        vecs[3] = '{3, 1'b1, 41};
        vecs[4] = '{0, 1'b1, 29};
        basic_wr[0] = 32'h0015_0005;
        basic_wr[1] = 32'h0017_0007;
        basic_wr[2] = 32'h001d_000d;
        basic_wr[3] = 32'h001f_000f;
        basic_win0 = 128'h0015_0014_0011_0010_0005_0004_0001_0000;
        basic_rd[0] = 2;  basic_rd[1] = 3;  basic_rd[2] = 6;  basic_rd[3] = 7;
        basic_rd[4] = 8;  basic_rd[5] = 9;  basic_rd[6] = 12; basic_rd[7] = 13;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), 0);
        check("reset_window", pool_data_in, 0);
        rst_n = 1'b1;

        for (int a = 0; a < W*H; a++)
            for (int c = 0; c < CH; c++)
                mem[a][c*BITS +: BITS] = BITS'(c*16'h10 + a);

        run_pass(1, 1'b0, dc, e1);
        check_pass("basic", dc, 33);
        for (int i = 0; i < 4 && i < wd_q.size(); i++)
            check("basic_wr_const", wd_q[i], basic_wr[i]);
        for (int i = 0; i < 8 && i + 4 < rd_q.size(); i++)
            check("basic_rd_order", rd_q[i+4], basic_rd[i]);
        if (win_q.size() > 0)
            check("basic_packing", win_q[0], basic_win0);

        foreach (vecs[v]) begin
            run_pass(vecs[v].dly, vecs[v].inject, dc, e1);
            check_pass($sformatf("vec%0d", v), dc, vecs[v].exp_done);
        end

        rdy_dly = 5;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        ps = 0;
        for (int n = 0; n < 200 && ps < 3; n++) begin
            @(negedge clk);
            if (pool_start) ps++;
        end
        check("midreset_reached", ps, 3);
        repeat (2) @(negedge clk);
        check("midreset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_outs", outs(), 0);
        check("midreset_window", pool_data_in, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_pass(1, 1'b0, dc, e1);
        if (rd_q.size() > 0) check("restart_addr0", rd_q[0], 0);
        check_pass("restart", dc, 33);

        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < W*H; a++) mem[a] = WORD'($urandom);
            run_pass(-2, 1'($urandom_range(0, 1)), dc, e1);
            e = 1;
            foreach (dly_q[i]) e += 7 + dly_q[i];
            check_pass($sformatf("rand%0d", r), dc, e);
        end

`ifdef POOL_CTRL_TIMEOUT_EN
        run_pass(-1, 1'b0, dc, e1);
        check("tmo_done_cyc", dc, 22);
        check("tmo_err", err, 1);
        check("tmo_no_write", wa_q.size(), 0);
        run_pass(1, 1'b0, dc, e1);
        check("tmo_err_cleared", e1, 0);
        check_pass("after_tmo", dc, 33);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
